// File: rtl/uart_pkg.sv
// Shared types and helpers for the oversampling UART receiver with its receive FIFO.
package uart_pkg;

  localparam int MAX_PAYLOAD_BITS = 9;

  typedef enum logic [1:0] {
    PAR_NONE = 2'd0,
    PAR_ODD  = 2'd1,
    PAR_EVEN = 2'd2
  } parity_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_BRK_WAIT
  } rx_state_e;

  typedef struct packed {
    logic                        brk;
    logic                        frame_err;
    logic                        parity_err;
    logic [MAX_PAYLOAD_BITS-1:0] data;
  } rx_entry_t;

  function automatic int calc_div(input int clk_hz, input int bit_rate, input int oversample);
    return clk_hz / (bit_rate * oversample);
  endfunction

endpackage

// File: rtl/uart_rx_fifo_ext_if.sv
// Valid/ready drain port carrying one received entry: payload plus error flags.
interface uart_rx_fifo_ext_if #(
  parameter int PAYLOAD_BITS = 8
);
  logic [PAYLOAD_BITS-1:0] m_data;
  logic                    m_parity_err;
  logic                    m_frame_err;
  logic                    m_break;
  logic                    m_valid;
  logic                    m_ready;

  modport master (
    output m_data, m_parity_err, m_frame_err, m_break, m_valid,
    input  m_ready
  );

  modport slave (
    input  m_data, m_parity_err, m_frame_err, m_break, m_valid,
    output m_ready
  );
endinterface

// File: rtl/uart_rx_fifo.sv
// Generic synchronous FIFO with a registered head; a push when full is ignored unless a pop frees a slot.
module uart_rx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic             empty_o,
  output logic             full_o
);
  localparam int AW = $clog2(DEPTH);

  if (DEPTH < 2 || (1 << AW) != DEPTH) begin : g_depth_chk
    $error("uart_rx_fifo: DEPTH must be a power of two >= 2");
  end

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] head_q, head_d;
  logic             valid_q, valid_d;
  logic             do_push, do_pop;

  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty_o = ~valid_q;
  assign head_o  = head_q;
  assign do_pop  = pop_i & valid_q;
  assign do_push = push_i & (~full_o | do_pop);

  // NOTE: every always_comb output is assigned a default first so no latch can be inferred.
  always_comb begin
    wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = do_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    valid_d  = (wr_ptr_d != rd_ptr_d);
    head_d   = mem_q[rd_ptr_d[AW-1:0]];
    if (do_push && (wr_ptr_q[AW-1:0] == rd_ptr_d[AW-1:0])) head_d = push_data_i;
    if (!valid_d) head_d = '0;
  end

  // NOTE: the storage array has no reset; pointers and the head register define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      head_q   <= '0;
      valid_q  <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      head_q   <= head_d;
      valid_q  <= valid_d;
    end
  end

endmodule

// File: rtl/uart_rx_fifo_ext.sv
// Oversampling UART receiver: majority-vote sampling, false-start rejection, parity/framing/break
// detection, feeding a small receive FIFO drained over a valid/ready port.
module uart_rx_fifo_ext
  import uart_pkg::*;
#(
  parameter int CLK_HZ       = 50_000_000,
  parameter int BIT_RATE     = 9600,
  parameter int OVERSAMPLE   = 16,
  parameter int PAYLOAD_BITS = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic                      uart_rxd,
  input  logic                      uart_rx_en,
  uart_rx_fifo_ext_if.master        m_if,
  output logic                      overrun,
  output logic                      busy
);
  localparam int      DIV      = calc_div(CLK_HZ, BIT_RATE, OVERSAMPLE);
  localparam int      DIV_W    = (DIV < 2) ? 1 : $clog2(DIV);
  localparam int      TICK_W   = $clog2(OVERSAMPLE);
  localparam int      ENTRY_W  = PAYLOAD_BITS + 3;
  localparam parity_e PAR_MODE = parity_e'(2'(PARITY));

  if (DIV < 2) begin : g_div_chk
    $error("uart_rx_fifo_ext: CLK_HZ/(BIT_RATE*OVERSAMPLE) must be >= 2");
  end
  if (OVERSAMPLE < 8 || OVERSAMPLE % 2 != 0 || PAYLOAD_BITS < 5 || PAYLOAD_BITS > 9 ||
      PARITY < 0 || PARITY > 2 || STOP_BITS < 1 || STOP_BITS > 2) begin : g_param_chk
    $error("uart_rx_fifo_ext: parameter out of range");
  end

  logic                    sync1_q, sync2_q, rxd_s;
  rx_state_e               state_q;
  logic [DIV_W-1:0]        div_cnt_q;
  logic [TICK_W-1:0]       tick_cnt_q, brk_cnt_q;
  logic [1:0]              samp_q;
  logic [3:0]              bit_cnt_q;
  logic [PAYLOAD_BITS-1:0] data_q;
  logic                    par_q, frame_err_q, push_q, overrun_q;
  logic [ENTRY_W-1:0]      entry_q, fifo_head;
  logic                    fifo_empty, fifo_full, pop;
  logic                    tick, at_decide, at_end, bit_val, frame_err_now, par_x;
  rx_entry_t               entry_d;

  assign rxd_s     = sync2_q;
  assign tick      = (state_q != S_IDLE) && (div_cnt_q == DIV_W'(DIV - 1));
  assign at_decide = tick && (tick_cnt_q == TICK_W'(OVERSAMPLE / 2 + 1));
  assign at_end    = tick && (tick_cnt_q == TICK_W'(OVERSAMPLE - 1));
  // Third vote is the live sample taken on the decision tick itself.
  assign bit_val   = (samp_q[0] & samp_q[1]) | (samp_q[0] & rxd_s) | (samp_q[1] & rxd_s);
  assign frame_err_now = frame_err_q | ~bit_val;

  always_comb begin
    entry_d           = '0;
    entry_d.data      = MAX_PAYLOAD_BITS'(data_q);
    entry_d.frame_err = frame_err_now;
    par_x             = ^entry_d.data ^ par_q;
    entry_d.parity_err = (PAR_MODE == PAR_ODD)  ? ~par_x :
                         (PAR_MODE == PAR_EVEN) ?  par_x : 1'b0;
    entry_d.brk       = frame_err_now && (entry_d.data == '0) && !par_q;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync1_q     <= 1'b1;
      sync2_q     <= 1'b1;
      state_q     <= S_IDLE;
      div_cnt_q   <= '0;
      tick_cnt_q  <= '0;
      brk_cnt_q   <= '0;
      samp_q      <= '0;
      bit_cnt_q   <= '0;
      data_q      <= '0;
      par_q       <= 1'b0;
      frame_err_q <= 1'b0;
      push_q      <= 1'b0;
      entry_q     <= '0;
      overrun_q   <= 1'b0;
    end else begin
      sync1_q   <= uart_rx_en ? uart_rxd : 1'b1;
      sync2_q   <= sync1_q;
      push_q    <= 1'b0;
      overrun_q <= push_q & fifo_full & ~pop;

      if (state_q == S_IDLE) begin
        div_cnt_q  <= '0;
        tick_cnt_q <= '0;
      end else if (tick) begin
        div_cnt_q  <= '0;
        tick_cnt_q <= (tick_cnt_q == TICK_W'(OVERSAMPLE - 1)) ? '0 : tick_cnt_q + 1'b1;
      end else begin
        div_cnt_q  <= div_cnt_q + 1'b1;
      end

      if (tick && tick_cnt_q == TICK_W'(OVERSAMPLE / 2 - 1)) samp_q[0] <= rxd_s;
      if (tick && tick_cnt_q == TICK_W'(OVERSAMPLE / 2))     samp_q[1] <= rxd_s;

      if (!uart_rx_en) begin
        state_q <= S_IDLE;
      end else begin
        case (state_q)
          S_IDLE: if (!rxd_s) begin
            state_q     <= S_START;
            bit_cnt_q   <= '0;
            par_q       <= 1'b0;
            frame_err_q <= 1'b0;
          end
          S_START: begin
            if (at_decide && bit_val) state_q <= S_IDLE;
            else if (at_end)          state_q <= S_DATA;
          end
          S_DATA: begin
            if (at_decide) data_q <= {bit_val, data_q[PAYLOAD_BITS-1:1]};
            if (at_end) begin
              if (bit_cnt_q == 4'(PAYLOAD_BITS - 1)) begin
                bit_cnt_q <= '0;
                state_q   <= (PAR_MODE == PAR_NONE) ? S_STOP : S_PARITY;
              end else begin
                bit_cnt_q <= bit_cnt_q + 1'b1;
              end
            end
          end
          S_PARITY: begin
            if (at_decide) par_q   <= bit_val;
            if (at_end)    state_q <= S_STOP;
          end
          S_STOP: begin
            if (at_decide) begin
              frame_err_q <= frame_err_now;
              if (bit_cnt_q == 4'(STOP_BITS - 1)) begin
                push_q    <= 1'b1;
                entry_q   <= {entry_d.brk, entry_d.frame_err, entry_d.parity_err,
                              entry_d.data[PAYLOAD_BITS-1:0]};
                brk_cnt_q <= '0;
                state_q   <= (frame_err_now && !rxd_s) ? S_BRK_WAIT : S_IDLE;
              end
            end else if (at_end) begin
              bit_cnt_q <= bit_cnt_q + 1'b1;
            end
          end
          S_BRK_WAIT: begin
            // Any low sample restarts the one-bit-period high qualification.
            if (!rxd_s) begin
              brk_cnt_q <= '0;
            end else if (tick) begin
              if (brk_cnt_q == TICK_W'(OVERSAMPLE - 1)) state_q   <= S_IDLE;
              else                                      brk_cnt_q <= brk_cnt_q + 1'b1;
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign pop = m_if.m_valid & m_if.m_ready;

  uart_rx_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (resetn),
    .push_i      (push_q),
    .push_data_i (entry_q),
    .pop_i       (pop),
    .head_o      (fifo_head),
    .empty_o     (fifo_empty),
    .full_o      (fifo_full)
  );

  assign m_if.m_data       = fifo_head[PAYLOAD_BITS-1:0];
  assign m_if.m_parity_err = fifo_head[PAYLOAD_BITS];
  assign m_if.m_frame_err  = fifo_head[PAYLOAD_BITS+1];
  assign m_if.m_break      = fifo_head[PAYLOAD_BITS+2];
  assign m_if.m_valid      = ~fifo_empty;
  assign overrun           = overrun_q;
  assign busy              = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx_fifo_ext.sv
// Directed bench: three receivers (8N1, 8E1, 8N2) at 4 clocks per oversample tick, 64 clocks per bit.
module tb_uart_rx_fifo_ext;
  localparam int CLK_HZ_TB = 614_400;
  localparam int BIT       = 64;

  logic       clk = 1'b0;
  logic       resetn;
  logic       rx_en;
  logic [2:0] rxd;
  logic       overrun_a, overrun_p, overrun_s;
  logic       busy_a, busy_p, busy_s;

  uart_rx_fifo_ext_if #(.PAYLOAD_BITS(8)) if_a ();
  uart_rx_fifo_ext_if #(.PAYLOAD_BITS(8)) if_p ();
  uart_rx_fifo_ext_if #(.PAYLOAD_BITS(8)) if_s ();

  uart_rx_fifo_ext #(.CLK_HZ(CLK_HZ_TB)) dut_a (
    .clk(clk), .resetn(resetn), .uart_rxd(rxd[0]), .uart_rx_en(rx_en),
    .m_if(if_a), .overrun(overrun_a), .busy(busy_a)
  );
  uart_rx_fifo_ext #(.CLK_HZ(CLK_HZ_TB), .PARITY(2)) dut_p (
    .clk(clk), .resetn(resetn), .uart_rxd(rxd[1]), .uart_rx_en(rx_en),
    .m_if(if_p), .overrun(overrun_p), .busy(busy_p)
  );
  uart_rx_fifo_ext #(.CLK_HZ(CLK_HZ_TB), .STOP_BITS(2)) dut_s (
    .clk(clk), .resetn(resetn), .uart_rxd(rxd[2]), .uart_rx_en(rx_en),
    .m_if(if_s), .overrun(overrun_s), .busy(busy_s)
  );

  always #5 clk = ~clk;

  // Entries as {break, frame_err, parity_err, data}, captured on every accepted pop.
  logic [10:0] got_a[$];
  logic [10:0] got_p[$];
  int vcyc_a = 0;
  int ovr_a  = 0;

  always @(negedge clk) begin
    if (if_a.m_valid && if_a.m_ready)
      got_a.push_back({if_a.m_break, if_a.m_frame_err, if_a.m_parity_err, if_a.m_data});
    if (if_p.m_valid && if_p.m_ready)
      got_p.push_back({if_p.m_break, if_p.m_frame_err, if_p.m_parity_err, if_p.m_data});
    if (if_a.m_valid) vcyc_a++;
    if (overrun_a)    ovr_a++;
  end

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] entry_at(input int lane, input int idx);
    if (lane == 0) return (idx < got_a.size()) ? {21'b0, got_a[idx]} : 32'hFFFF_FFFF;
    return (idx < got_p.size()) ? {21'b0, got_p[idx]} : 32'hFFFF_FFFF;
  endfunction

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bits(input int lane, input logic [15:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      rxd[lane] = bits[i];
      wait_clk(BIT);
    end
    rxd[lane] = 1'b1;
  endtask

  int base, vb, ob;

  initial begin
    resetn = 1'b0;
    rx_en  = 1'b1;
    rxd    = 3'b111;
    if_a.m_ready = 1'b1;
    if_p.m_ready = 1'b1;
    if_s.m_ready = 1'b0;
    wait_clk(3);
    check("rst_valid", {31'b0, if_a.m_valid}, 0);
    check("rst_data", {24'b0, if_a.m_data}, 0);
    check("rst_flags", {29'b0, if_a.m_break, if_a.m_frame_err, if_a.m_parity_err}, 0);
    check("rst_overrun", {31'b0, overrun_a}, 0);
    check("rst_busy", {31'b0, busy_a}, 0);
    resetn = 1'b1;
    wait_clk(2 * BIT);

    // 8N1 0xA5 with the consumer always ready
    base = got_a.size(); vb = vcyc_a;
    send_bits(0, 16'({1'b1, 8'hA5, 1'b0}), 10);
    wait_clk(BIT);
    check("a5_count", got_a.size() - base, 1);
    check("a5_entry", entry_at(0, base), 32'h0A5);
    check("a5_valid_cycles", vcyc_a - vb, 1);
    check("a5_valid_after", {31'b0, if_a.m_valid}, 0);

    // Three-tick glitch must be rejected, then 0x5A received
    base = got_a.size(); vb = vcyc_a;
    rxd[0] = 1'b0;
    wait_clk(12);
    rxd[0] = 1'b1;
    wait_clk(2 * BIT);
    check("glitch_busy", {31'b0, busy_a}, 0);
    check("glitch_no_valid", vcyc_a - vb, 0);
    send_bits(0, 16'({1'b1, 8'h5A, 1'b0}), 10);
    wait_clk(BIT);
    check("glitch_5a_count", got_a.size() - base, 1);
    check("glitch_5a_entry", entry_at(0, base), 32'h05A);

    // Break: line low for two frame times, then 0x11 after the line recovers
    base = got_a.size();
    rxd[0] = 1'b0;
    wait_clk(20 * BIT);
    check("brk_busy_low", {31'b0, busy_a}, 1);
    rxd[0] = 1'b1;
    wait_clk(3 * BIT);
    check("brk_count", got_a.size() - base, 1);
    check("brk_entry", entry_at(0, base), 32'h600);
    send_bits(0, 16'({1'b1, 8'h11, 1'b0}), 10);
    wait_clk(BIT);
    check("brk_11_count", got_a.size() - base, 2);
    check("brk_11_entry", entry_at(0, base + 1), 32'h011);

    // Enable dropped mid-frame discards the partial frame
    base = got_a.size();
    rxd[0] = 1'b0;
    wait_clk(3 * BIT);
    check("en_busy_mid", {31'b0, busy_a}, 1);
    rx_en = 1'b0;
    wait_clk(1);
    check("en_busy_off", {31'b0, busy_a}, 0);
    rxd[0] = 1'b1;
    wait_clk(2 * BIT);
    rx_en = 1'b1;
    wait_clk(2 * BIT);
    check("en_no_push", got_a.size() - base, 0);

    // Overrun: five frames into a four-deep FIFO with the consumer stalled
    if_a.m_ready = 1'b0;
    base = got_a.size(); ob = ovr_a;
    for (int d = 1; d <= 5; d++) begin
      send_bits(0, 16'({1'b1, 8'(d), 1'b0}), 10);
      wait_clk(BIT);
    end
    check("ovr_pulses", ovr_a - ob, 1);
    check("ovr_head_valid", {31'b0, if_a.m_valid}, 1);
    check("ovr_head_data", {24'b0, if_a.m_data}, 32'h01);
    if_a.m_ready = 1'b1;
    wait_clk(10);
    check("ovr_drain_count", got_a.size() - base, 4);
    for (int i = 0; i < 4; i++)
      check($sformatf("ovr_drain_%0d", i), entry_at(0, base + i), 32'(i + 1));
    check("ovr_empty", {31'b0, if_a.m_valid}, 0);

    // Even parity: 0x37 has five ones, so the correct parity bit is 1
    base = got_p.size();
    send_bits(1, 16'({1'b1, 1'b0, 8'h37, 1'b0}), 11);
    wait_clk(BIT);
    send_bits(1, 16'({1'b1, 1'b1, 8'h37, 1'b0}), 11);
    wait_clk(BIT);
    check("par_count", got_p.size() - base, 2);
    check("par_bad_entry", entry_at(1, base), 32'h137);
    check("par_good_entry", entry_at(1, base + 1), 32'h037);

    // Two stop bits, second one low; entry held at the head, then reset mid-frame
    send_bits(2, 16'({1'b0, 1'b1, 8'hC3, 1'b0}), 11);
    wait_clk(3 * BIT);
    check("stop2_valid", {31'b0, if_s.m_valid}, 1);
    check("stop2_data", {24'b0, if_s.m_data}, 32'hC3);
    check("stop2_flags", {29'b0, if_s.m_break, if_s.m_frame_err, if_s.m_parity_err}, 32'h2);
    check("stop2_idle", {31'b0, busy_s}, 0);
    rxd[2] = 1'b0;
    wait_clk(3 * BIT);
    check("stop2_busy_mid", {31'b0, busy_s}, 1);
    #3;
    resetn = 1'b0;
    #1;
    check("rstmid_valid", {31'b0, if_s.m_valid}, 0);
    check("rstmid_busy", {31'b0, busy_s}, 0);
    check("rstmid_data", {24'b0, if_s.m_data}, 0);
    rxd = 3'b111;
    wait_clk(4);
    resetn = 1'b1;
    wait_clk(4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_rx_fifo_ext.md
Name: uart_rx_fifo_ext

Overview:
Parametrised successor to the team's single-frame UART receiver. Adds oversampled majority-vote bit sampling, false-start rejection, optional parity, 1 or 2 stop bits, parity/framing/break detection, and a small receive FIFO with a valid/ready drain port and overrun reporting. Sits between the board RX pin and any byte-stream consumer (command decoder, DMA bridge).

Parameters:
CLK_HZ, 50_000_000, system clock frequency in Hz
BIT_RATE, 9600, line baud rate
OVERSAMPLE, 16, sample ticks per bit; even, >=8
PAYLOAD_BITS, 8, data bits per frame, 5..9
PARITY, 0, 0=none, 1=odd, 2=even
STOP_BITS, 1, 1 or 2
FIFO_DEPTH, 4, receive FIFO entries; power of two, >=2

Ports:
clk  in  1  system clock
resetn  in  1  asynchronous active-low reset
uart_rxd  in  1  raw asynchronous serial input, idle high
uart_rx_en  in  1  receiver enable
m_data  out  PAYLOAD_BITS  head-of-FIFO payload, LSB = first received bit
m_parity_err  out  1  head entry failed parity (0 when PARITY=0)
m_frame_err  out  1  head entry had a low stop bit
m_break  out  1  head entry is a break condition
m_valid  out  1  FIFO non-empty
m_ready  in  1  consumer accepts head entry
overrun  out  1  one-cycle pulse: completed frame dropped, FIFO full
busy  out  1  FSM not in IDLE

Behaviour:
- Reset (async, resetn=0): FSM IDLE, FIFO empty, synchronizer flops =1, all counters 0; m_valid=0, m_data=0, all m_* flags 0, overrun=0, busy=0.
- Input: 2-flop synchronizer on uart_rxd; while uart_rx_en=0 its input is forced to 1.
- Tick prescaler: DIV = CLK_HZ/(BIT_RATE*OVERSAMPLE), integer division, must be >=2 (elaborate-time error otherwise). One-cycle tick each DIV clocks; prescaler and tick counter (0..OVERSAMPLE-1) clear on leaving IDLE.
- Bit value = majority of samples at ticks OVERSAMPLE/2-1, OVERSAMPLE/2, OVERSAMPLE/2+1. Bit decided at tick OVERSAMPLE/2+1; bit period ends at tick OVERSAMPLE-1.
- FSM: IDLE -> START on synchronized rxd=0. START: majority=1 -> IDLE (false start, nothing pushed); else at bit end -> DATA. DATA: shifts PAYLOAD_BITS bits LSB first; after last -> PARITY if PARITY!=0 else STOP. PARITY: one bit, then STOP. STOP: STOP_BITS bits; frame_err set if any stop bit decides 0. Entry pushed on the cycle after the last stop bit's decision tick (not at bit end), FSM -> IDLE same edge; if frame_err and line still low -> BRK_WAIT instead.
- BRK_WAIT: hold until synchronized rxd=1 for one full bit period (OVERSAMPLE ticks), then IDLE. No pushes in BRK_WAIT.
- Parity: odd => data XOR parity bit must be 1; even => must be 0.
- Break: data all zero, parity bit (if any) 0, frame_err=1 -> entry pushed with m_break=1, m_frame_err=1.
- uart_rx_en deasserted mid-frame: FSM -> IDLE next cycle, partial frame discarded, FIFO untouched.
- FIFO: entry = {break, frame_err, parity_err, data}. Head outputs registered; m_valid rises 1 cycle after push into empty FIFO. Pop on m_valid & m_ready. Push when full and no pop: entry dropped, overrun pulses 1 cycle, FIFO unchanged. Push and pop same cycle when full: both succeed, no overrun. Pointers wrap modulo FIFO_DEPTH with an extra wrap bit for full/empty.
- Reset mid-frame or mid-drain: everything to reset values immediately; FIFO contents lost.

Decomposition:
- Package uart_pkg: parity enum (NONE/ODD/EVEN), rx FSM state enum (IDLE, START, DATA, PARITY, STOP, BRK_WAIT), rx entry struct {break, frame_err, parity_err, data}, DIV compute function.
- Sub-module uart_rx_fifo: generic synchronous FIFO (width, depth params) with push/pop/full/empty; receiver instantiates it with entry width PAYLOAD_BITS+3.

Test Plan:
- Defaults, send 0xA5 (8N1) with m_ready=1 -> one entry: m_data=0xA5, all flags 0, m_valid high for exactly 1 cycle.
- PARITY=2, send 0x37 with parity bit 0 (wrong; correct is 1) -> m_data=0x37, m_parity_err=1, m_frame_err=0.
- Glitch: rxd low for 3 ticks then high -> FSM returns IDLE, no push, m_valid stays 0; following 0x5A received correctly.
- Line held low 2 frame times then released -> exactly one entry m_data=0x00, m_break=1, m_frame_err=1; next 0x11 received after line idle one bit period.
- FIFO_DEPTH=4, m_ready=0, send 0x01..0x05 -> overrun pulses once after 5th frame; drain yields 0x01,0x02,0x03,0x04 in order.
- STOP_BITS=2, second stop bit driven 0 on 0xC3 -> m_frame_err=1; assert resetn=0 mid-next-frame -> m_valid=0, busy=0 immediately.
